vector_sequencer: RTL
=====================

Name: vector_sequencer

Overview:
- Parametrised command sequencer for the vector display path.
- Accepts jump/draw commands through a valid/ready stream. Orchestrates the line generator and the DAC serialiser through port-level handshakes, with runtime-programmable dwell counts and multi-bit beam intensity.
- Sits between the command source (frame buffer / UART parser) and the lineto + DAC blocks. Drop-in successor to the fixed-dwell, 12-bit, on/off-beam controller.

Parameters:
- W, 12, coordinate / DAC value width
- ZW, 4, beam intensity width
- DW, 13, dwell counter width
- SKIP_NULL_JUMP, 1, 1 = a jump to the current position completes with no dwell and no line reset

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  1  0 = jump, 1 = draw
- cmd_x, cmd_y  in  W  target coordinate
- cmd_z  in  ZW  draw intensity (ignored for jump)
- cfg_jump_pre, cfg_jump_post, cfg_draw_pre, cfg_draw_post  in  DW each  dwell step counts
- line_reset  out  1  force line generator to line_x/line_y
- line_strobe  out  1  start a line to line_x/line_y
- line_next  out  1  request next line point
- line_x, line_y  out  W  latched target
- line_ready  in  1  line generator idle
- line_axis  in  1  axis of current line point
- line_xo, line_yo  in  W  line generator output point
- dac_ready  in  1  DAC accepting a value
- dac_strobe  out  1  equals dac_ready (combinational)
- dac_axis  out  1  0 = X, 1 = Y
- dac_value  out  W  dac_axis ? line_yo : line_xo
- beam  out  ZW  beam intensity
- busy  out  1  state != IDLE

Behaviour:
- Step: any cycle with dac_ready=1.
- Reset values: all state registers cleared. beam=0, dac_axis=0, line_strobe=0, line_next=0, line_x/line_y=0, state=IDLE. Tracked position cur_x/cur_y=0.
- Reset mid-operation aborts the command at once. Any held command is not consumed.
- line_reset = reset | (state==JUMP_MOVE).
- cmd_ready = (state==IDLE) & dac_ready & line_ready. A command is accepted on cmd_valid & cmd_ready. cmd_* is sampled only at accept.
- States: IDLE, JUMP_PRE, JUMP_MOVE, JUMP_POST, DRAW_PRE, DRAW_RUN, DRAW_POST.
- Jump accept:
  - beam<=0; line_x/line_y and cur_x/cur_y <= cmd_x/cmd_y.
  - If SKIP_NULL_JUMP and cmd == cur: stay IDLE.
  - Otherwise go to JUMP_PRE, dwell<=cfg_jump_pre.
- JUMP_PRE: each step, dwell==0 -> JUMP_MOVE, else dwell-1. Pre-dwell therefore lasts cfg+1 steps.
- JUMP_MOVE: line_reset high. At the next step: dac_axis<=1, dwell<=cfg_jump_post, go to JUMP_POST.
- JUMP_POST: each step, dwell==0 -> IDLE, else dwell-1.
- Draw accept:
  - beam<=cmd_z; line_x/line_y and cur <= cmd_x/cmd_y.
  - line_strobe=1 for exactly one cycle.
  - dwell<=cfg_draw_pre, go to DRAW_PRE.
- DRAW_PRE: each step, dwell==0 -> DRAW_RUN with line_next<=1 and dac_axis<=line_axis; else dwell-1.
- DRAW_RUN:
  - Each step: line_next<=1, dac_axis<=line_axis.
  - Non-step cycle with line_ready=1 and line_next=0: dwell<=cfg_draw_post, go to DRAW_POST. This transition takes priority over clearing pulses.
- DRAW_POST: each step, dwell==0 -> IDLE, else dwell-1.
- line_next and line_strobe are single-cycle pulses. They clear on the first non-step cycle after assertion.
- beam holds its value after draw completion. Only a jump or reset clears it. cmd_z=0 draws blanked.
- Dwell counters are unsigned DW bits and never underflow. cfg changes take effect only at the next dwell load.
- Back-to-back: the next command can be accepted the first cycle IDLE & dac_ready & line_ready.
- Null-jump skip returns cmd_ready high the next cycle if ready conditions hold.

Test Plan:
- Reset, then jump (0x100, 0x200) with cfg_jump_pre=3, cfg_jump_post=5, dac_ready=1 continuous -> 4 steps JUMP_PRE, 1 cycle line_reset, 6 steps JUMP_POST. beam=0, busy falls on cycle 12 after accept.
- Draw to (0x300, 0x200), cmd_z=9, cfg_draw_pre=0, cfg_draw_post=2, model line generator emitting 4 points -> line_strobe one cycle, beam=9, 4 line_next pulses, dac_axis tracks line_axis, 3 post steps then IDLE. beam stays 9.
- Jump to the current position with SKIP_NULL_JUMP=1 -> no line_reset, busy never asserted, cmd_ready high next cycle, beam=0.
- dac_ready toggling 1-of-4 cycles during JUMP_POST with cfg=2 -> dwell decrements only on dac_ready cycles. Exit after 3 steps.
- cmd_valid held high during DRAW_RUN -> cmd_ready=0, command not consumed until IDLE. Then accepted exactly once.
- Assert reset during DRAW_RUN -> next cycle state=IDLE, beam=0, line_next=0, line_reset=1 during reset, held command not lost.

Source files
------------

// File: rtl/vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vector_sequencer
// Purpose  : Jump/draw command sequencer driving the line generator and DAC
//            serialiser, with programmable dwell counts and beam intensity.
// Revision : 1.0
// ============================================================================
module vector_sequencer #(
    parameter int W              = 12,
    parameter int ZW             = 4,
    parameter int DW             = 13,
    parameter int SKIP_NULL_JUMP = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [W-1:0]  cmd_x,
    input  logic [W-1:0]  cmd_y,
    input  logic [ZW-1:0] cmd_z,
    input  logic [DW-1:0] cfg_jump_pre,
    input  logic [DW-1:0] cfg_jump_post,
    input  logic [DW-1:0] cfg_draw_pre,
    input  logic [DW-1:0] cfg_draw_post,
    output logic          line_reset,
    output logic          line_strobe,
    output logic          line_next,
    output logic [W-1:0]  line_x,
    output logic [W-1:0]  line_y,
    input  logic          line_ready,
    input  logic          line_axis,
    input  logic [W-1:0]  line_xo,
    input  logic [W-1:0]  line_yo,
    input  logic          dac_ready,
    output logic          dac_strobe,
    output logic          dac_axis,
    output logic [W-1:0]  dac_value,
    output logic [ZW-1:0] beam,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_JUMP_PRE  = 3'd1,
        S_JUMP_MOVE = 3'd2,
        S_JUMP_POST = 3'd3,
        S_DRAW_PRE  = 3'd4,
        S_DRAW_RUN  = 3'd5,
        S_DRAW_POST = 3'd6
    } state_t;

    state_t        r_state,       w_state_next;
    logic [DW-1:0] r_dwell,       w_dwell_next;
    logic [ZW-1:0] r_beam,        w_beam_next;
    logic          r_dac_axis,    w_dac_axis_next;
    logic          r_line_strobe, w_line_strobe_next;
    logic          r_line_next,   w_line_next_next;
    logic [W-1:0]  r_line_x,      w_line_x_next;
    logic [W-1:0]  r_line_y,      w_line_y_next;
    logic [W-1:0]  r_cur_x,       w_cur_x_next;
    logic [W-1:0]  r_cur_y,       w_cur_y_next;

    logic w_step;
    logic w_accept;
    logic w_null_jump;
    logic w_dwell_zero;

    assign w_step       = dac_ready;
    assign cmd_ready    = (r_state == S_IDLE) & dac_ready & line_ready;
    assign w_accept     = cmd_valid & cmd_ready;
    assign w_null_jump  = (SKIP_NULL_JUMP != 0) && (cmd_x == r_cur_x) && (cmd_y == r_cur_y);
    assign w_dwell_zero = (r_dwell == '0);

    assign line_reset  = reset | (r_state == S_JUMP_MOVE);
    assign line_strobe = r_line_strobe;
    assign line_next   = r_line_next;
    assign line_x      = r_line_x;
    assign line_y      = r_line_y;
    assign dac_strobe  = dac_ready;
    assign dac_axis    = r_dac_axis;
    assign dac_value   = r_dac_axis ? line_yo : line_xo;
    assign beam        = r_beam;
    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_dwell       <= '0;
            r_beam        <= '0;
            r_dac_axis    <= 1'b0;
            r_line_strobe <= 1'b0;
            r_line_next   <= 1'b0;
            r_line_x      <= '0;
            r_line_y      <= '0;
            r_cur_x       <= '0;
            r_cur_y       <= '0;
        end else begin
            r_state       <= w_state_next;
            r_dwell       <= w_dwell_next;
            r_beam        <= w_beam_next;
            r_dac_axis    <= w_dac_axis_next;
            r_line_strobe <= w_line_strobe_next;
            r_line_next   <= w_line_next_next;
            r_line_x      <= w_line_x_next;
            r_line_y      <= w_line_y_next;
            r_cur_x       <= w_cur_x_next;
            r_cur_y       <= w_cur_y_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_dwell_next       = r_dwell;
        w_beam_next        = r_beam;
        w_dac_axis_next    = r_dac_axis;
        w_line_strobe_next = r_line_strobe;
        w_line_next_next   = r_line_next;
        w_line_x_next      = r_line_x;
        w_line_y_next      = r_line_y;
        w_cur_x_next       = r_cur_x;
        w_cur_y_next       = r_cur_y;

        if (w_step) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_line_x_next = cmd_x;
                        w_line_y_next = cmd_y;
                        w_cur_x_next  = cmd_x;
                        w_cur_y_next  = cmd_y;
                        if (!cmd_op) begin
                            w_beam_next = '0;
                            if (!w_null_jump) begin
                                w_dwell_next = cfg_jump_pre;
                                w_state_next = S_JUMP_PRE;
                            end
                        end else begin
                            w_beam_next        = cmd_z;
                            w_line_strobe_next = 1'b1;
                            w_dwell_next       = cfg_draw_pre;
                            w_state_next       = S_DRAW_PRE;
                        end
                    end
                end
                S_JUMP_PRE: begin
                    if (w_dwell_zero) w_state_next = S_JUMP_MOVE;
                    else              w_dwell_next = r_dwell - DW'(1);
                end
                S_JUMP_MOVE: begin
                    w_dac_axis_next = 1'b1;
                    w_dwell_next    = cfg_jump_post;
                    w_state_next    = S_JUMP_POST;
                end
                S_JUMP_POST: begin
                    if (w_dwell_zero) w_state_next = S_IDLE;
                    else              w_dwell_next = r_dwell - DW'(1);
                end
                S_DRAW_PRE: begin
                    if (w_dwell_zero) begin
                        w_state_next     = S_DRAW_RUN;
                        w_line_next_next = 1'b1;
                        w_dac_axis_next  = line_axis;
                    end else begin
                        w_dwell_next = r_dwell - DW'(1);
                    end
                end
                S_DRAW_RUN: begin
                    w_line_next_next = 1'b1;
                    w_dac_axis_next  = line_axis;
                end
                S_DRAW_POST: begin
                    if (w_dwell_zero) w_state_next = S_IDLE;
                    else              w_dwell_next = r_dwell - DW'(1);
                end
                default: w_state_next = S_IDLE;
            endcase
        end else if ((r_state == S_DRAW_RUN) && line_ready && !r_line_next) begin
            // Line finished and its last point has been handed over.
            w_dwell_next = cfg_draw_post;
            w_state_next = S_DRAW_POST;
        end else begin
            w_line_strobe_next = 1'b0;
            w_line_next_next   = 1'b0;
        end
    end

endmodule
`default_nettype wire
